// File: rtl/fma_result_packer.sv
// Converts signed fixed-point accumulator results to binary32 (RNE) in three stages, then queues them in a show-ahead FIFO.
// Define FMA_PACK_SUBNORM_EN to produce subnormals instead of flushing tiny results to zero.
module fma_result_packer #(
  parameter int MANT_W     = 50,
  parameter int FRAC_W     = 47,
  parameter int EXP_W      = 8,
  parameter int BIAS       = 127,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_fp32,
  output logic [15:0]       ovf_cnt
);

  localparam int E_W = EXP_W + $clog2(MANT_W) + 2;
  localparam int P_W = $clog2(MANT_W);
  localparam int A_W = $clog2(FIFO_DEPTH);
  localparam int C_W = A_W + 1;
  localparam logic signed [E_W-1:0] E_MAX = E_W'(255);
  localparam logic signed [E_W-1:0] E_ONE = E_W'(1);
`ifdef FMA_PACK_SUBNORM_EN
  localparam logic signed [E_W-1:0] E_SUB_MIN = -E_W'(23);
`endif

  logic                     in_fire;
  logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic                     sign1_q, sign1_d, inf1_q, inf1_d;
  logic [MANT_W-1:0]        mag1_q, mag1_d;
  logic [EXP_W-1:0]         exp1_q, exp1_d;
  logic                     sign2_q, sign2_d, inf2_q, inf2_d, zero2_q, zero2_d;
  logic [MANT_W-1:0]        norm2_q, norm2_d;
  logic signed [E_W-1:0]    e2_q, e2_d;
  logic [P_W-1:0]           lead;
  logic [31:0]              res3_q, res3_d;
  logic [15:0]              ovf_cnt_q, ovf_cnt_d;
  logic [31:0]              mem_q [FIFO_DEPTH];
  logic [31:0]              mem_d [FIFO_DEPTH];
  logic [A_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [C_W-1:0]           count_q, count_d;
  logic [C_W+1:0]           occ;
  logic                     push, pop;

  // rounding signals
  logic [22:0]              frac_raw, frac_n;
  logic                     guard, sticky, round_up, carry, ovf;
  logic [24:0]              sig_r;
  logic signed [E_W-1:0]    e_r;
`ifdef FMA_PACK_SUBNORM_EN
  logic [2*MANT_W-1:0]      sub_wide;
  logic [P_W-1:0]           sub_sh;
  logic [23:0]              sub_frac, sub_sig;
  logic                     sub_guard, sub_sticky, sub_up;
`endif

  // Admission counts results still in the pipeline so a FIFO write never finds it full.
  always_comb begin
    occ      = (C_W+2)'(count_q) + (C_W+2)'(v1_q) + (C_W+2)'(v2_q) + (C_W+2)'(v3_q);
    in_ready = occ < (C_W+2)'(FIFO_DEPTH);
    in_fire  = in_valid && in_ready;
  end

  always_comb begin
    v1_d    = in_fire;
    sign1_d = in_mant[MANT_W-1];
    mag1_d  = in_mant[MANT_W-1] ? (~in_mant + MANT_W'(1)) : in_mant;
    exp1_d  = in_exp;
    inf1_d  = &in_exp;
  end

  always_comb begin
    lead = '0;
    for (int i = 0; i < MANT_W; i++) begin
      if (mag1_q[i]) lead = P_W'(i);
    end
    v2_d    = v1_q;
    sign2_d = sign1_q;
    inf2_d  = inf1_q;
    zero2_d = (mag1_q == '0);
    norm2_d = mag1_q << (P_W'(MANT_W - 1) - lead);
    e2_d    = E_W'(exp1_q) + E_W'(lead) - E_W'(FRAC_W) + E_W'(127 - BIAS);
  end

  always_comb begin
    frac_raw = norm2_q[MANT_W-2 -: 23];
    guard    = norm2_q[MANT_W-25];
    sticky   = |norm2_q[MANT_W-26:0];
    round_up = guard && (sticky || frac_raw[0]);
    sig_r    = {2'b01, frac_raw} + 25'(round_up);
    carry    = sig_r[24];
    frac_n   = carry ? 23'h0 : sig_r[22:0];
    e_r      = e2_q + E_W'(carry);
`ifdef FMA_PACK_SUBNORM_EN
    sub_sh     = P_W'(E_ONE - e2_q);
    sub_wide   = {norm2_q, {MANT_W{1'b0}}} >> sub_sh;
    sub_frac   = sub_wide[2*MANT_W-1 -: 24];
    sub_guard  = sub_wide[2*MANT_W-25];
    sub_sticky = |sub_wide[2*MANT_W-26:0];
    sub_up     = sub_guard && (sub_sticky || sub_frac[0]);
    sub_sig    = sub_frac + 24'(sub_up);
`endif
    v3_d   = v2_q;
    ovf    = 1'b0;
    res3_d = 32'h0;
    if (zero2_q) begin
      res3_d = 32'h0;
    end else if (inf2_q) begin
      res3_d = {sign2_q, 8'hFF, 23'h0};
    end else if (e_r >= E_MAX) begin
      res3_d = {sign2_q, 8'hFF, 23'h0};
      ovf    = 1'b1;
`ifdef FMA_PACK_SUBNORM_EN
    end else if (e2_q < E_ONE) begin
      // a carry into bit 23 lands in the exponent LSB, giving the minimum normal
      if (e2_q < E_SUB_MIN) res3_d = {sign2_q, 31'h0};
      else                  res3_d = {sign2_q, 8'(sub_sig[23]), sub_sig[22:0]};
`else
    end else if (e_r < E_ONE) begin
      res3_d = {sign2_q, 31'h0};
`endif
    end else begin
      res3_d = {sign2_q, e_r[7:0], frac_n};
    end
    ovf_cnt_d = ovf_cnt_q;
    if (v2_q && ovf && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_comb begin
    push     = v3_q;
    pop      = (count_q != '0) && out_ready;
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = res3_q;
    wr_ptr_d = wr_ptr_q + A_W'(push);
    rd_ptr_d = rd_ptr_q + A_W'(pop);
    count_d  = count_q + C_W'(push) - C_W'(pop);
  end

  assign out_valid = (count_q != '0);
  assign out_fp32  = out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign ovf_cnt   = ovf_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      ovf_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      ovf_cnt_q <= ovf_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Datapath registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    sign1_q <= sign1_d;
    mag1_q  <= mag1_d;
    exp1_q  <= exp1_d;
    inf1_q  <= inf1_d;
    sign2_q <= sign2_d;
    inf2_q  <= inf2_d;
    zero2_q <= zero2_d;
    norm2_q <= norm2_d;
    e2_q    <= e2_d;
    res3_q  <= res3_d;
    mem_q   <= mem_d;
  end

endmodule

// File: tb/tb_fma_result_packer.sv
// Directed plus randomized bench for fma_result_packer with an arithmetic reference model and an output scoreboard.
module tb_fma_result_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_exp;
  logic [49:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_fp32;
  logic [15:0] ovf_cnt;

  int          checks = 0;
  int          failures = 0;
  int          pops = 0;
  int          ovf_exp = 0;
  logic [31:0] exp_q [$];

  fma_result_packer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_exp(in_exp), .in_mant(in_mant), .out_valid(out_valid),
    .out_ready(out_ready), .out_fp32(out_fp32), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer rounding by comparing the discarded remainder with one half ulp.
  function automatic void ref_pack(input logic [7:0] ex, input logic [49:0] mt,
                                   output logic [31:0] res, output bit ovf);
    logic               s;
    logic signed [63:0] sv;
    logic [63:0]        mag, q, rem, half;
    int                 p, e, sh;
    s   = mt[49];
    sv  = {{14{mt[49]}}, mt};
    mag = s ? 64'(-sv) : 64'(sv);
    ovf = 1'b0;
    res = 32'h0;
    if (mag == 64'd0) return;
    if (ex == 8'hFF) begin res = {s, 8'hFF, 23'h0}; return; end
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    e = int'(ex) + p - 47;
    if (p >= 23) begin
      sh  = p - 23;
      q   = mag >> sh;
      rem = mag - (q << sh);
      if (sh > 0) begin
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      end
    end else begin
      q = mag << (23 - p);
    end
    if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
    if (e >= 255) begin res = {s, 8'hFF, 23'h0}; ovf = 1'b1; end
    else if (e <= 0) res = {s, 31'h0};
    else res = {s, 8'(e), q[22:0]};
  endfunction

  // Scoreboard: record accepted inputs, check every pop in order.
  always @(negedge clk) begin
    logic [31:0] r, e;
    bit          o;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL unexpected_output: observed=%0h expected=none", out_fp32);
        end else begin
          e = exp_q.pop_front();
          check("out_fp32", 64'(out_fp32), 64'(e));
          pops++;
        end
      end
      if (in_valid && in_ready) begin
        ref_pack(in_exp, in_mant, r, o);
        exp_q.push_back(r);
        if (o && ovf_exp != 65535) ovf_exp++;
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] ex, input logic [49:0] mt);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_exp   = ex;
    in_mant  = mt;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $error("FAIL send_timeout: observed=not_accepted expected=accepted");
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) cyc(1);
    cyc(2);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  logic [7:0]  bp_e [6];
  logic [49:0] bp_m [6];
  int          idx, pops0;
  logic [63:0] rnd;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b0;
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_fp32", 64'(out_fp32), 64'd0);
    check("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // latency: handshake at edge k, visible only after edge k+3
    send(8'd127, 50'd1 << 47);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lat_not_yet", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_value", 64'(out_fp32), 64'h3F800000);
    @(posedge clk); #1;
    out_ready = 1'b1;

    send(8'd128, -(50'd3 << 46));
    send(8'd200, 50'd0);
    send(8'd127, (50'd1 << 47) + (50'd1 << 23));
    send(8'd127, (50'd1 << 47) + (50'd3 << 23));
    send(8'd127, (50'd1 << 47) + (50'd1 << 23) + 50'd1);
    send(8'd1, 50'd1 << 46);
    send(8'd127, 50'h2_0000_0000_0000);
    drain();
    check("no_ovf_yet", 64'(ovf_cnt), 64'd0);
    send(8'd254, 50'd1 << 48);
    drain();
    check("ovf_cnt_one", 64'(ovf_cnt), 64'd1);
    send(8'd255, {50{1'b1}});
    drain();
    check("inf_no_ovf", 64'(ovf_cnt), 64'(ovf_exp));

    // backpressure: six offered, four accepted while the output is stalled
    for (int i = 0; i < 6; i++) begin
      bp_e[i] = 8'(120 + i);
      bp_m[i] = 50'(64'd3 << (40 + i)) + 50'(i * 7);
    end
    out_ready = 1'b0;
    idx = 0;
    pops0 = pops;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_exp = bp_e[idx]; in_mant = bp_m[idx];
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
    end
    check("bp_accepted", 64'(idx), 64'd4);
    @(negedge clk);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && idx < 6; c++) begin
      in_valid = 1'b1; in_exp = bp_e[idx]; in_mant = bp_m[idx];
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", 64'(idx), 64'd6);
    drain();
    check("bp_out_count", 64'(pops - pops0), 64'd6);

    // reset with two buffered and two in flight
    out_ready = 1'b0;
    send(8'd130, 50'd5 << 45);
    send(8'd131, 50'd7 << 44);
    cyc(5);
    send(8'd250, 50'd1 << 49);
    send(8'd126, 50'd9 << 43);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    exp_q.delete();
    ovf_exp = 0;
    @(negedge clk);
    check("rstm_out_valid", 64'(out_valid), 64'd0);
    check("rstm_ovf_cnt", 64'(ovf_cnt), 64'd0);
    check("rstm_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    cyc(10);
    pops0 = pops;
    send(8'd127, -(50'd1 << 47));
    drain();
    check("rstm_new_only", 64'(pops - pops0), 64'd1);

    // randomized traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      rnd       = {$urandom, $urandom};
      rnd       = rnd >> $urandom_range(0, 49);
      in_mant   = rnd[49:0];
      if ($urandom_range(0, 1) == 1) in_mant = -in_mant;
      if ($urandom_range(0, 15) == 0) in_mant = {1'b1, 49'h0};
      in_exp    = 8'($urandom_range(0, 255));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    in_valid = 1'b0;
    drain();
    check("rand_ovf_cnt", 64'(ovf_cnt), 64'(ovf_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fma_result_packer.md
Name: fma_result_packer

Overview:
- Drain-side counterpart of the FMA pipeline.
- Accepts normalized-signed accumulator results (biased exponent plus two's-complement fixed-point mantissa) on a valid/ready interface.
- Converts each result to packed IEEE-754 binary32 (round-to-nearest-even) in a 3-stage pipeline, then buffers the results in a credit-protected output FIFO toward the array's result collector.

Parameters:
- MANT_W, 50: width of the signed accumulator mantissa.
- FRAC_W, 47: fraction bits of the mantissa. Value = in_mant / 2^FRAC_W * 2^(in_exp - BIAS).
- EXP_W, 8: width of the accumulator exponent.
- BIAS, 127: exponent bias, identical to the binary32 bias.
- FIFO_DEPTH, 4: number of output FIFO entries; must be a power of two and at least 2.

Ports:
- clk, in, 1: clock; all logic is rising-edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: input result is valid.
- in_ready, out, 1: block can accept an input this cycle.
- in_exp, in, EXP_W: biased exponent; all-ones means infinity.
- in_mant, in, MANT_W: signed two's-complement mantissa.
- out_valid, out, 1: out_fp32 holds a valid result.
- out_ready, in, 1: downstream consumes the result this cycle.
- out_fp32, out, 32: packed binary32 result.
- ovf_cnt, out, 16: saturating count of results forced to infinity by overflow.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: out_valid=0, out_fp32=0, ovf_cnt=0, in_ready=1. Reset clears all pipeline valid bits and the FIFO pointers and occupancy.
- Input handshake: a transfer occurs on a rising edge where in_valid && in_ready.
- in_ready = (fifo_count + inflight) < FIFO_DEPTH, where inflight is the number of valid pipeline stages.
  - in_ready is registered-free combinational from state only; it never depends on in_valid.
  - The pipeline itself never stalls, and a FIFO write can never find the FIFO full.
- S1 (registered at the handshake edge): capture sign = in_mant[MANT_W-1] and mag = |in_mant| as MANT_W-bit unsigned. The most-negative mantissa yields mag = 2^(MANT_W-1) with no overflow. Also capture in_exp and an isInf flag (in_exp all-ones).
- S2: leading-one position p of mag (0..MANT_W-1). Left-normalize mag so its leading one is at the MSB. Compute biased result exponent e = in_exp + p - FRAC_W as a signed value of EXP_W+$clog2(MANT_W)+2 bits.
- S3, rounding:
  - Take 23 fraction bits below the leading one.
  - Guard is the next bit; sticky is the OR of all remaining bits.
  - Round up if guard && (sticky || lsb).
  - If rounding carries out, shift right by one and set e = e+1.
- S3, special cases (first match wins):
  - mag==0: result {sign=0, 31'b0}, i.e. +0.
  - isInf: {sign, 8'hFF, 23'b0}.
  - e >= 255: {sign, 8'hFF, 23'b0}; ovf_cnt increments, saturating at 16'hFFFF.
  - e <= 0: {sign, 31'b0}, flush-to-zero (subnormals per Optional Feature).
  - Otherwise: {sign, e[7:0], frac}.
- Latency: a result accepted at edge k is written to the FIFO at edge k+3. With an empty FIFO, out_valid=1 and out_fp32 is valid after edge k+3.
- Throughput: one result per cycle when out_ready stays high.
- Output FIFO is show-ahead: out_fp32 shows the head entry while out_valid=1. The entry pops on out_valid && out_ready.
  - Simultaneous push and pop leaves the count unchanged, at any occupancy.
  - A pop on empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Ordering: results leave strictly in input order.
- Reset mid-operation: in-flight and buffered results are discarded; no output in the cycle after reset.

Optional Feature:
- Macro: FMA_PACK_SUBNORM_EN.
- Defined: when e <= 0 and e >= -23, produce a subnormal. The significand (with its implicit one) is right-shifted by 1-e before the RNE rounding, and the exponent field is 0. If rounding carries into bit 23, the result becomes the minimum normal 0x00800000 (with sign). When e < -23, the result is signed zero after rounding.
- Undefined: flush-to-zero as described in Behaviour. The extra shifter is not instantiated.

Test Plan:
- in_exp=127, in_mant=1<<47 -> out_fp32=0x3F800000, 3 cycles after the handshake.
- in_exp=128, in_mant=-(3<<46) -> 0xC0400000. Also in_mant=0, any exponent -> 0x00000000.
- RNE ties: in_exp=127 with mant (1<<47)+(1<<23) -> 0x3F800000; with mant (1<<47)+(3<<23) -> 0x3F800002; with mant (1<<47)+(1<<23)+1 -> 0x3F800001.
- Overflow/infinity:
  - in_exp=254, in_mant=1<<48 -> 0x7F800000 and ovf_cnt=1.
  - in_exp=255, in_mant=-1 -> 0xFF800000 and ovf_cnt unchanged.
- Backpressure: hold out_ready=0 and offer 6 back-to-back inputs -> exactly 4 accepted, in_ready=0 afterwards. Then raise out_ready -> the 4 results leave in order, the remaining 2 are then accepted, no loss or duplication.
- Reset mid-stream: assert rst for 1 cycle with 2 results in flight and 2 buffered -> out_valid=0 and ovf_cnt=0 the next cycle, in_ready=1, and none of the old results ever appear.
